// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage valid/ready immediate extender (sign, zero, scaled sign, upper-place).
// S1 holds the raw immediate; S2 holds the extended result and the scaling-overflow flag.
module imm_extend_pipe #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_imm_i,
  input  logic [1:0]       in_mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_ovf_o
);
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic             s1_adv, s2_adv, in_fire;
  logic [IN_W-1:0]  s1_imm_q;
  logic [1:0]       s1_mode_q;
  logic [OUT_W-1:0] sext, zext, upper, scaled, res_d, s2_data_q;
  logic [SHAMT:0]   top;
  logic             ovf_d, s2_ovf_q;
  generate
    if (IN_W == OUT_W) begin : g_same
      assign sext  = s1_imm_q;
      assign zext  = s1_imm_q;
      assign upper = s1_imm_q;
    end else begin : g_wide
      assign sext  = {{(OUT_W-IN_W){s1_imm_q[IN_W-1]}}, s1_imm_q};
      assign zext  = {{(OUT_W-IN_W){1'b0}}, s1_imm_q};
      assign upper = {s1_imm_q, {(OUT_W-IN_W){1'b0}}};
    end
  endgenerate
  assign scaled = sext << SHAMT;
  // Scaling keeps the signed value only if the bits shifted out all match the new sign bit.
  assign top    = sext[OUT_W-1 -: SHAMT+1];
  assign ovf_d  = (s1_mode_q == 2'd2) && !((&top) || !(|top));
  assign res_d  = s1_mode_q == 2'd0 ? sext :
                  s1_mode_q == 2'd1 ? zext :
                  s1_mode_q == 2'd2 ? scaled : upper;
  assign s2_adv     = !s2_valid_q || out_ready_i;
  assign s1_adv     = s1_valid_q && s2_adv;
  assign in_ready_o = (!s1_valid_q || s2_adv) && !flush_i;
  assign in_fire    = in_valid_i && in_ready_o;
  assign s1_valid_d = flush_i ? 1'b0 : in_fire ? 1'b1 : s1_adv ? 1'b0 : s1_valid_q;
  assign s2_valid_d = flush_i ? 1'b0 : s1_adv ? 1'b1 : out_ready_i ? 1'b0 : s2_valid_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_imm_q   <= '0;
      s1_mode_q  <= '0;
      s2_data_q  <= '0;
      s2_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) begin
        s1_imm_q  <= in_imm_i;
        s1_mode_q <= in_mode_i;
      end
      if (s1_adv) begin
        s2_data_q <= res_d;
        s2_ovf_q  <= ovf_d;
      end
    end
  end
  assign out_valid_o = s2_valid_q;
  assign out_data_o  = s2_data_q;
  assign out_ovf_o   = s2_ovf_q;
endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension unit for the KGP-RISC datapath, generalising the fixed 19-to-32-bit sign extender. Takes an IN_W-bit immediate plus a 2-bit mode and produces an OUT_W-bit operand: sign-extended, zero-extended, sign-extended and scaled for branch offsets, or upper-placed. Sits between instruction decode and the ALU/branch-target operand muxes. Uses a two-stage valid/ready pipeline so decode can be stalled by the execute stage without losing immediates.

## Interface
- IN_W, 19, immediate input width; legal range 1..OUT_W
- OUT_W, 32, result width
- SHAMT, 2, left-shift amount for mode 2; legal range 0..OUT_W-1
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous pipeline clear (branch redirect)
- in_valid  input  1  immediate/mode present
- in_ready  output  1  unit can accept this cycle
- in_imm  input  IN_W  raw immediate field
- in_mode  input  2  0 sign-ext, 1 zero-ext, 2 sign-ext then shift left SHAMT, 3 upper-place
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  OUT_W  extended result
- out_ovf  output  1  mode-2 scaling lost significance

## Operation
- Stage 1 (S1): registers in_imm, in_mode, s1_valid on an input transfer (in_valid && in_ready).
- Stage 2 (S2): registers computed out_data, out_ovf, s2_valid from S1.
- Mode 0: out = {(OUT_W-IN_W){imm[IN_W-1]}, imm}.
- Mode 1: out = {(OUT_W-IN_W){0}, imm}.
- Mode 2: out = (mode-0 value) << SHAMT, truncated to OUT_W; zeros shifted in.
- Mode 3: out = imm << (OUT_W-IN_W); low bits zero. IN_W==OUT_W gives out = imm.
- IN_W==OUT_W: modes 0 and 1 pass imm unchanged.
- out_ovf: mode 2 only; 1 when the mode-0 value's top SHAMT+1 bits are not all equal (signed value not representable after scaling). Always 0 for modes 0, 1, 3 and when SHAMT==0.
- Advance rules: s2_adv = !s2_valid || out_ready; s1_adv = s1_valid && s2_adv. in_ready = (!s1_valid || s2_adv) && !flush.
- Full throughput 1 result/cycle when out_ready held high; in-order, no drop, no duplication.
- While out_valid && !out_ready: out_data, out_ovf held stable; S1 holds its entry; at most 2 immediates in flight.
- flush: s1_valid and s2_valid cleared next edge; in_ready is 0 in the flush cycle, so no input is accepted. A result with out_ready high in the flush cycle counts as consumed.
- Data registers need not clear on flush; only valid bits matter.

## Timing
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_ovf=0. in_ready=1 once rst_n high (combinational from cleared state).
- Reset mid-operation: in-flight entries discarded immediately, no later output from them.
- Latency: input accepted at edge N -> out_valid at edge N+2 (no stall).
- in_ready is combinational from out_ready, flush and valid state; no combinational path from in_valid/in_imm to any output.
- Simultaneous consume at S2 and accept at S1 in the same cycle is legal when full; pipeline stays full, throughput maintained.

## Test plan
- Modes at IN_W=19, OUT_W=32, SHAMT=2: imm 0x40000 mode 0 -> 0xFFFC0000; mode 1 -> 0x00040000; imm 0x7FFFF mode 2 -> 0xFFFFFFFC ovf=0; imm 0x12345 mode 3 -> 0x2468A000; each out_valid exactly 2 cycles after accept.
- Overflow at IN_W=8, OUT_W=8, SHAMT=2: imm 0x40 mode 2 -> out 0x00, ovf=1; imm 0xF0 mode 2 -> 0xC0, ovf=0; imm 0x40 mode 0 -> 0x40, ovf=0.
- Back-pressure: out_ready=0, in_valid=1 with imm 1,2,3 on consecutive cycles -> only 1,2 accepted, in_ready=0 on third, out_data held at 1; raise out_ready -> 1,2,3 emitted in order, one per cycle.
- Streaming: 16 back-to-back inputs with out_ready=1 -> 16 results on consecutive cycles, in_ready never low.
- Flush: both stages valid, assert flush one cycle with in_valid=1 -> in_ready=0 that cycle, out_valid=0 next cycle, held input accepted the cycle after flush drops.
- Async reset: rst_n low mid-stream between clock edges -> out_valid, out_data, out_ovf go 0 without waiting for clk; after release the first new input yields its result 2 cycles after acceptance, no stale data.
